// File: rtl/nvidia_pkg.sv
// ---------------------------------------------------------------------------
// nvidia_pkg
// Shared definitions for the scatter block and its sibling gather block.
//   scatter_state_t : FSM state encoding of the scatter assembly buffer
//   idx_width()     : slot-selector width; one extra code above the last slot
//                     so the value BLOCK_SIZE can mean "lane unused"
//   lane_width()    : width needed to name one input lane (minimum 1 bit)
// ---------------------------------------------------------------------------
package nvidia_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } scatter_state_t;

    function automatic int idx_width(input int block_size);
        return $clog2(block_size + 1);
    endfunction

    function automatic int lane_width(input int num_select);
        return (num_select > 1) ? $clog2(num_select) : 1;
    endfunction

endpackage

// File: rtl/nvidia_scatter_decode.sv
// ---------------------------------------------------------------------------
// nvidia_scatter_decode
// Combinational slot decoder for the scatter block. For every slot of the
// assembly buffer it reports whether any live lane of the current beat
// targets it, and which lane wins (highest lane index). It also flags a
// collision when two or more lanes of the same beat target one slot.
//
// Ports
//   valid_i      : beat is being accepted this cycle (gates all enables)
//   idx_i        : destination slot per lane; >= BLOCK_SIZE means unused
//   slot_we_o    : per-slot write enable
//   slot_lane_o  : per-slot winning lane number (valid where slot_we_o=1)
//   collide_o    : some slot targeted by more than one lane in this beat
// ---------------------------------------------------------------------------
module nvidia_scatter_decode
    import nvidia_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_SELECT = 3,
    parameter int IDX_W      = idx_width(BLOCK_SIZE),
    parameter int LANE_W     = lane_width(NUM_SELECT)
) (
    input  logic                                valid_i,
    input  logic [NUM_SELECT-1:0][IDX_W-1:0]    idx_i,
    output logic [BLOCK_SIZE-1:0]               slot_we_o,
    output logic [BLOCK_SIZE-1:0][LANE_W-1:0]   slot_lane_o,
    output logic                                collide_o
);

    // A lane is live only if its index names a real slot.
    logic [NUM_SELECT-1:0] lane_live;

    always_comb begin
        lane_live = '0;
        for (int i = 0; i < NUM_SELECT; i++) begin
            lane_live[i] = valid_i && (idx_i[i] < IDX_W'(BLOCK_SIZE));
        end
    end

    // Lanes are walked in ascending order so a later (higher) lane simply
    // overwrites the winner recorded by an earlier one. Finding the slot
    // already enabled when a lane arrives is exactly an intra-beat conflict.
    always_comb begin
        slot_we_o   = '0;
        slot_lane_o = '0;
        collide_o   = 1'b0;
        for (int s = 0; s < BLOCK_SIZE; s++) begin
            for (int i = 0; i < NUM_SELECT; i++) begin
                if (lane_live[i] && (idx_i[i] == IDX_W'(s))) begin
                    if (slot_we_o[s]) begin
                        collide_o = 1'b1;
                    end
                    slot_we_o[s]   = 1'b1;
                    slot_lane_o[s] = LANE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/nvidia_scatter.sv
// ---------------------------------------------------------------------------
// nvidia_scatter
// Scatters NUM_SELECT tagged words per beat into a BLOCK_SIZE-word assembly
// buffer and hands the finished block downstream. A block closes when every
// slot has been written or the producer flags the last beat; it is then
// held on the output until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is a pure function of the registered state (high
// in FILL, low in EMIT). out_valid is high throughout EMIT and only drops
// after the edge at which out_ready was sampled high. A producer offered
// in_ready=0 must hold its beat unchanged.
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   in_valid     : input beat present
//   in_ready     : buffer can accept a beat (FILL state)
//   in_data      : lane words
//   in_idx       : destination slot per lane (>= BLOCK_SIZE = unused lane)
//   in_last      : close the block after this beat even if partially filled
//   out_valid    : assembled block present (EMIT state)
//   out_ready    : consumer takes the block
//   out_data     : assembled words, unfilled slots read 0
//   out_mask     : per-slot written flag for this block
//   out_collide  : some slot of this block was written more than once
//   dbg_state    : current FSM state, for observation only
// ---------------------------------------------------------------------------
module nvidia_scatter
    import nvidia_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int NUM_SELECT = 3,
    parameter int WORD_SIZE  = 8,
    parameter int IDX_W      = idx_width(BLOCK_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_SELECT-1:0][WORD_SIZE-1:0]  in_data,
    input  logic [NUM_SELECT-1:0][IDX_W-1:0]      in_idx,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0]  out_data,
    output logic [BLOCK_SIZE-1:0]                 out_mask,
    output logic                                  out_collide,
    output scatter_state_t                        dbg_state
);

    localparam int LANE_W = lane_width(NUM_SELECT);

    scatter_state_t                       state_q,   state_d;
    logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] data_q,    data_d;
    logic [BLOCK_SIZE-1:0]                mask_q,    mask_d;
    logic                                 collide_q, collide_d;

    logic                                 accept;
    logic [BLOCK_SIZE-1:0]                slot_we;
    logic [BLOCK_SIZE-1:0][LANE_W-1:0]    slot_lane;
    logic                                 intra_collide;
    logic                                 inter_collide;

    assign accept = (state_q == FILL) && in_valid;

    nvidia_scatter_decode #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_SELECT (NUM_SELECT),
        .IDX_W      (IDX_W),
        .LANE_W     (LANE_W)
    ) u_decode (
        .valid_i     (accept),
        .idx_i       (in_idx),
        .slot_we_o   (slot_we),
        .slot_lane_o (slot_lane),
        .collide_o   (intra_collide)
    );

    // Writing a slot that an earlier beat of this block already filled.
    assign inter_collide = |(slot_we & mask_q);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        collide_d = collide_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int s = 0; s < BLOCK_SIZE; s++) begin
                        if (slot_we[s]) begin
                            data_d[s] = in_data[slot_lane[s]];
                        end
                    end
                    mask_d    = mask_q | slot_we;
                    collide_d = collide_q | intra_collide | inter_collide;
                    // An all-unused last beat still closes the block.
                    if ((&mask_d) || in_last) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                // Clearing on hand-off leaves the buffer empty for the next
                // block, so unfilled slots of that block read as zero.
                if (out_ready) begin
                    data_d    = '0;
                    mask_d    = '0;
                    collide_d = 1'b0;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            data_q    <= '0;
            mask_q    <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            collide_q <= collide_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == EMIT);
    assign out_data    = data_q;
    assign out_mask    = mask_q;
    assign out_collide = collide_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nvidia_scatter.sv
module tb_nvidia_scatter;
  import nvidia_pkg::*;

  localparam int BS = 4;
  localparam int NS = 3;
  localparam int WS = 8;
  localparam int IW = 3;
  localparam int W  = 1 + BS + BS * WS;  // {collide, mask, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [NS-1:0][WS-1:0]     in_data = '0;
  logic [NS-1:0][IW-1:0]     in_idx = '0;
  logic                      in_last = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [BS-1:0][WS-1:0]     out_data;
  logic [BS-1:0]             out_mask;
  logic                      out_collide;
  scatter_state_t            dbg_state;

  nvidia_scatter #(
    .BLOCK_SIZE (BS),
    .NUM_SELECT (NS),
    .WORD_SIZE  (WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_idx      (in_idx),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mask    (out_mask),
    .out_collide (out_collide),
    .dbg_state   (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // Builds the block word by word from the lane writes in lane order; a
  // write landing on an already-written slot marks the block collided.
  logic [W-1:0] exp_q[$];
  logic [WS-1:0] m_word[BS];
  logic [BS-1:0] m_mask;
  logic          m_coll;
  bit            m_emit;

  task automatic model_clear();
    for (int s = 0; s < BS; s++) m_word[s] = '0;
    m_mask = '0;
    m_coll = 1'b0;
  endtask

  initial begin
    model_clear();
    m_emit = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        model_clear();
        exp_q.delete();
        m_emit = 1'b0;
      end else if (m_emit) begin
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_emit = 1'b0;
        end
      end else if (in_valid) begin
        logic [BS*WS-1:0] packed_words;
        for (int i = 0; i < NS; i++) begin
          int slot;
          slot = int'(in_idx[i]);
          if (slot < BS) begin
            if (m_mask[slot]) m_coll = 1'b1;
            m_word[slot] = in_data[i];
            m_mask[slot] = 1'b1;
          end
        end
        if (m_mask == '1 || in_last) begin
          for (int s = 0; s < BS; s++) packed_words[s*WS +: WS] = m_word[s];
          exp_q.push_back({m_coll, m_mask, packed_words});
          model_clear();
          m_emit = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (started && !rst) begin
        check("in_ready", 64'(in_ready), 64'(!m_emit));
        check("out_valid", 64'(out_valid), 64'(m_emit));
        if (m_emit) begin
          if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'(0), 64'(1));
          end else begin
            check("out_data", 64'(out_data), 64'(exp_q[0][BS*WS-1:0]));
            check("out_mask", 64'(out_mask), 64'(exp_q[0][BS*WS +: BS]));
            check("out_collide", 64'(out_collide), 64'(exp_q[0][W-1]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                            input logic [IW-1:0] i2, input logic [WS-1:0] d0,
                            input logic [WS-1:0] d1, input logic [WS-1:0] d2,
                            input logic last);
    int budget;
    in_idx[0] = i0; in_idx[1] = i1; in_idx[2] = i2;
    in_data[0] = d0; in_data[1] = d1; in_data[2] = d2;
    in_last  = last;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("beat_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_block();
    int budget;
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!out_valid) check("out_timeout", 64'(0), 64'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("fill_after_take", 64'(in_ready), 64'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;

    // Reset then idle
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_mask", 64'(out_mask), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(FILL));
    repeat (2) @(posedge clk);
    #1;

    // Full block over two beats, unused lanes ignored
    drive_beat(3'd0, 3'd1, 3'd2, 8'hA0, 8'hA1, 8'hA2, 1'b0);
    check("ab_not_yet", 64'(out_valid), 64'(0));
    drive_beat(3'd3, 3'd4, 3'd4, 8'hB0, 8'h55, 8'h66, 1'b0);
    check("ab_latency", 64'(out_valid), 64'(1));
    check("ab_data", 64'(out_data), 64'h00000000_B0A2A1A0);
    check("ab_mask", 64'(out_mask), 64'hF);
    check("ab_collide", 64'(out_collide), 64'(0));
    check("ab_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("ab_held", 64'(out_valid), 64'(1));
    take_block();
    check("ab_cleared_mask", 64'(out_mask), 64'(0));

    // Intra-beat conflict with in_last on a partial block
    drive_beat(3'd2, 3'd2, 3'd4, 8'h11, 8'h22, 8'h77, 1'b1);
    check("intra_data", 64'(out_data), 64'h00000000_00220000);
    check("intra_mask", 64'(out_mask), 64'b0100);
    check("intra_collide", 64'(out_collide), 64'(1));
    take_block();

    // Inter-beat conflict
    drive_beat(3'd0, 3'd1, 3'd4, 8'h01, 8'h02, 8'hEE, 1'b0);
    check("inter_partial_collide", 64'(out_collide), 64'(0));
    drive_beat(3'd1, 3'd2, 3'd3, 8'h03, 8'h04, 8'h05, 1'b0);
    check("inter_data", 64'(out_data), 64'h00000000_05040301);
    check("inter_mask", 64'(out_mask), 64'hF);
    check("inter_collide", 64'(out_collide), 64'(1));
    take_block();

    // Back-pressure: block held while a beat waits
    drive_beat(3'd0, 3'd1, 3'd2, 8'h10, 8'h20, 8'h30, 1'b0);
    drive_beat(3'd3, 3'd4, 3'd4, 8'h40, 8'hFF, 8'hFF, 1'b0);
    in_idx[0] = 3'd0; in_idx[1] = 3'd4; in_idx[2] = 3'd4;
    in_data[0] = 8'h99; in_data[1] = 8'h98; in_data[2] = 8'h97;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_data", 64'(out_data), 64'h00000000_40302010);
      check("hold_mask", 64'(out_mask), 64'hF);
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_fill", 64'(dbg_state), 64'(FILL));
    check("hold_release_mask", 64'(out_mask), 64'(0));
    check("hold_release_collide", 64'(out_collide), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("held_beat_valid", 64'(out_valid), 64'(1));
    check("held_beat_data", 64'(out_data), 64'h00000000_00000099);
    check("held_beat_mask", 64'(out_mask), 64'b0001);
    check("held_beat_collide", 64'(out_collide), 64'(0));
    take_block();

    // Last beat with all lanes unused closes an empty block
    drive_beat(3'd4, 3'd5, 3'd7, 8'hDE, 8'hAD, 8'hBE, 1'b1);
    check("empty_valid", 64'(out_valid), 64'(1));
    check("empty_mask", 64'(out_mask), 64'(0));
    check("empty_data", 64'(out_data), 64'(0));
    check("empty_collide", 64'(out_collide), 64'(0));
    take_block();

    // Reset mid-block discards partial data
    drive_beat(3'd0, 3'd1, 3'd4, 8'hAA, 8'hBB, 8'hCC, 1'b0);
    check("mid_mask", 64'(out_mask), 64'b0011);
    pulse_reset();
    check("mid_rst_mask", 64'(out_mask), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(FILL));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    drive_beat(3'd3, 3'd2, 3'd1, 8'hC3, 8'hC2, 8'hC1, 1'b0);
    drive_beat(3'd0, 3'd4, 3'd4, 8'hC0, 8'h00, 8'h00, 1'b0);
    check("post_rst_data", 64'(out_data), 64'h00000000_C3C2C1C0);
    check("post_rst_mask", 64'(out_mask), 64'hF);
    check("post_rst_collide", 64'(out_collide), 64'(0));
    take_block();

    // Reset during EMIT drops the pending block
    drive_beat(3'd1, 3'd1, 3'd4, 8'h12, 8'h34, 8'h00, 1'b1);
    check("emit_before_rst", 64'(out_valid), 64'(1));
    pulse_reset();
    check("emit_rst_valid", 64'(out_valid), 64'(0));
    check("emit_rst_data", 64'(out_data), 64'(0));
    check("emit_rst_collide", 64'(out_collide), 64'(0));

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nvidia_scatter.md
# nvidia_scatter

Inverse of the block's gather crossbar: instead of selecting NUM_SELECT words out of a BLOCK_SIZE block, it accepts NUM_SELECT words per beat, each tagged with a destination slot, and scatters them into a BLOCK_SIZE-word assembly buffer. When every slot is filled, or the producer marks the last beat, it presents the assembled block downstream with a valid/ready handshake. It sits between the select/compute stage and block-wide consumers (writeback, store path).

## Interface
- BLOCK_SIZE, 4: words per assembled block
- NUM_SELECT, 3: lanes (words) accepted per input beat
- WORD_SIZE, 8: bits per word
- IDX_W, derived = $clog2(BLOCK_SIZE+1): slot index width; value BLOCK_SIZE or greater means "lane unused"

Ports:
- clk  input  1  sole clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat
- in_data  input  [NUM_SELECT][WORD_SIZE]  lane words
- in_idx  input  [NUM_SELECT][IDX_W]  destination slot per lane
- in_last  input  1  close block after this beat, even if partially filled
- out_valid  output  1  assembled block present
- out_ready  input  1  consumer takes block
- out_data  output  [BLOCK_SIZE][WORD_SIZE]  assembled words; unfilled slots read 0
- out_mask  output  [BLOCK_SIZE]  1 = slot written in this block
- out_collide  output  1  some slot written more than once in this block

## Operation
- Two states: FILL, EMIT. Reset enters FILL.
- FILL: in_ready=1, out_valid=0. On in_valid: each lane i with in_idx[i] < BLOCK_SIZE writes in_data[i] into slot in_idx[i] and sets out_mask bit.
- Intra-beat conflict: several lanes targeting the same slot -> highest lane index wins; out_collide set.
- Inter-beat conflict: a lane targeting a slot whose mask bit is already set overwrites it; out_collide set.
- Lanes with in_idx >= BLOCK_SIZE are ignored; they set no flags.
- Transition FILL->EMIT after an accepted beat if resulting mask is all ones or in_last=1. A beat with in_last=1 and all lanes unused still closes the block (mask may be 0).
- EMIT: in_ready=0, out_valid=1, out_data/out_mask/out_collide stable. On out_ready: clear data to 0, mask to 0, collide to 0; go FILL.
- in_valid without acceptance (EMIT) has no effect; producer must hold the beat.

## Timing
- Reset values: state FILL, in_ready=1 in the first cycle after reset, out_valid=0, out_data=0, out_mask=0, out_collide=0.
- Latency: closing beat accepted at edge t -> out_valid=1 in cycle t+1.
- Handshake transfers on posedge when valid && ready. out_valid is held until accepted and never drops early.
- Throughput: one beat per cycle in FILL. EMIT costs at least one cycle with in_ready=0; peak rate is one block per (beats+1) cycles.
- in_ready depends only on state (registered), never on in_valid/out_ready.
- rst asserted in any state, mid-block or mid-EMIT: the partial block is discarded, all outputs return to reset values next cycle.
- While in FILL, out_data/out_mask are undefined to consumers; only values under out_valid are meaningful.

## Structure
- Shared package nvidia_pkg: scatter_state_t enum {FILL, EMIT}; function idx_width(block_size) returning $clog2(block_size+1); shared by the gather block for its selector width.
- One sub-module: nvidia_scatter_decode, combinational. It turns in_idx/in_valid into a per-slot write-enable, the winning lane number per slot, and an intra-beat collision flag. The top level holds the FSM, buffer, mask and flags.

## Test plan
BLOCK_SIZE=4, NUM_SELECT=3, WORD_SIZE=8.
- Reset then idle -> in_ready=1, out_valid=0, out_mask=0000, out_data all 0.
- Beat idx={0,1,2} data={A0,A1,A2}, then beat idx={3,4,4} data={B0,xx,xx} -> out_valid next cycle, out_data={A0,A1,A2,B0}, mask=1111, collide=0; in_ready=0 until out_ready.
- Single beat idx={2,2,4} data={11,22,xx} with in_last=1 -> slot2=22, mask=0100, collide=1, other slots 0.
- Beat idx={0,1,4} data={01,02}, then idx={1,2,3} data={03,04,05} -> slot1=03, mask=1111, collide=1.
- Block held with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, no beat accepted. Then out_ready=1 -> FILL next cycle, held beat accepted, mask/collide cleared.
- rst pulse after one beat (mask=0011) -> next cycle mask=0000, state FILL. Following full block assembles correctly with no residue.
